// File: rtl/dcache_ctrl_if.sv
// Bundle of the CPU-side request port and the main-memory port of the data cache.
// The slave modport is the cache controller; the master modport is the surrounding system.
interface dcache_ctrl_if;
  logic        req_valid;
  logic        req_we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [2:0]  funct3;
  logic        flush;
  logic [31:0] rdata;
  logic        stall;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ready;
  logic [31:0] mem_rdata;

  modport master (
    output req_valid, req_we, addr, wdata, funct3, flush, mem_ready, mem_rdata,
    input  rdata, stall, mem_req, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    input  req_valid, req_we, addr, wdata, funct3, flush, mem_ready, mem_rdata,
    output rdata, stall, mem_req, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/dcache_ctrl.sv
// Set-associative write-back / write-allocate data cache, one 32-bit word per line,
// with round-robin replacement and a full-cache flush that writes back dirty lines.
module dcache_ctrl #(
  parameter int WAYS = 2,
  parameter int SETS = 64
) (
  input  logic         clk,
  input  logic         rst,
  dcache_ctrl_if.slave bus
);
  localparam int IDX_W = $clog2(SETS);
  localparam int WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1;
  localparam int TAG_W = 30 - IDX_W;

  typedef enum logic [1:0] {IDLE, WB, FILL, FLUSH} state_t;

  state_t           r_state;
  logic [WAYS-1:0]  r_valid [SETS];
  logic [WAYS-1:0]  r_dirty [SETS];
  logic [WAY_W-1:0] r_rr    [SETS];
  logic [TAG_W-1:0] r_tag   [SETS][WAYS];
  logic [31:0]      r_data  [SETS][WAYS];

  logic             r_mem_req;
  logic             r_mem_we;
  logic [31:0]      r_mem_addr;
  logic [31:0]      r_mem_wdata;
  logic [IDX_W-1:0] r_cap_idx;
  logic [TAG_W-1:0] r_cap_tag;
  logic [WAY_W-1:0] r_cap_way;
  logic [IDX_W-1:0] r_fl_set;
  logic [WAY_W-1:0] r_fl_way;

  logic [IDX_W-1:0] w_idx;
  logic [TAG_W-1:0] w_tag;
  logic [WAYS-1:0]  w_match;
  logic [WAY_W-1:0] w_hit_way;
  logic [WAY_W-1:0] w_victim;
  logic             w_any;
  logic             w_hit;
  logic             w_miss;
  logic             w_victim_dirty;
  logic             w_fl_dirty;
  logic             w_fl_step;
  logic             w_fl_way_end;
  logic             w_fl_last;

  function automatic logic [31:0] load_ext(input logic [31:0] word, input logic [2:0] f3,
                                           input logic [1:0] off);
    logic [7:0]  b;
    logic [15:0] h;
    b = word[{off, 3'b000} +: 8];
    h = off[1] ? word[31:16] : word[15:0];
    case (f3)
      3'b000:  load_ext = {{24{b[7]}}, b};
      3'b001:  load_ext = {{16{h[15]}}, h};
      3'b100:  load_ext = {24'd0, b};
      3'b101:  load_ext = {16'd0, h};
      default: load_ext = word;
    endcase
  endfunction

  function automatic logic [31:0] store_merge(input logic [31:0] old, input logic [31:0] wd,
                                              input logic [2:0] f3, input logic [1:0] off);
    logic [31:0] r;
    r = old;
    case (f3[1:0])
      2'b00:   r[{off, 3'b000} +: 8]     = wd[7:0];
      2'b01:   r[{off[1], 4'b0000} +: 16] = wd[15:0];
      default: r = wd;
    endcase
    return r;
  endfunction

  assign w_idx = bus.addr[IDX_W+1:2];
  assign w_tag = bus.addr[31:IDX_W+2];

  // Descending scan so the lowest-index match / invalid way wins.
  always_comb begin
    w_match   = '0;
    w_hit_way = '0;
    w_victim  = r_rr[w_idx];
    for (int w = WAYS - 1; w >= 0; w--) begin
      w_match[w] = r_valid[w_idx][w] && (r_tag[w_idx][w] == w_tag);
      if (w_match[w]) w_hit_way = WAY_W'(w);
      if (!r_valid[w_idx][w]) w_victim = WAY_W'(w);
    end
  end

  assign w_any          = |w_match;
  assign w_hit          = (r_state == IDLE) && bus.req_valid && !bus.flush && w_any;
  assign w_miss         = (r_state == IDLE) && bus.req_valid && !bus.flush && !w_any;
  assign w_victim_dirty = r_valid[w_idx][w_victim] && r_dirty[w_idx][w_victim];

  assign w_fl_dirty   = r_valid[r_fl_set][r_fl_way] && r_dirty[r_fl_set][r_fl_way];
  assign w_fl_step    = r_mem_req ? bus.mem_ready : !w_fl_dirty;
  assign w_fl_way_end = (r_fl_way == WAY_W'(WAYS - 1));
  assign w_fl_last    = w_fl_way_end && (r_fl_set == IDX_W'(SETS - 1));

  // A flush arriving alongside a request holds the pipeline so the access retries afterwards.
  assign bus.stall     = (r_state != IDLE) || (bus.req_valid && (bus.flush || !w_any));
  assign bus.rdata     = load_ext(r_data[w_idx][w_hit_way], bus.funct3, bus.addr[1:0]);
  assign bus.mem_req   = r_mem_req;
  assign bus.mem_we    = r_mem_we;
  assign bus.mem_addr  = r_mem_addr;
  assign bus.mem_wdata = r_mem_wdata;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_fl_set    <= '0;
      r_fl_way    <= '0;
      for (int s = 0; s < SETS; s++) begin
        r_valid[s] <= '0;
        r_dirty[s] <= '0;
        r_rr[s]    <= '0;
      end
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.flush) begin
            r_state  <= FLUSH;
            r_fl_set <= '0;
            r_fl_way <= '0;
          end else if (w_hit) begin
            if (bus.req_we) r_dirty[w_idx][w_hit_way] <= 1'b1;
          end else if (w_miss) begin
            r_cap_idx <= w_idx;
            r_cap_tag <= w_tag;
            r_cap_way <= w_victim;
            r_mem_req <= 1'b1;
            if (w_victim_dirty) begin
              r_state     <= WB;
              r_mem_we    <= 1'b1;
              r_mem_addr  <= {r_tag[w_idx][w_victim], w_idx, 2'b00};
              r_mem_wdata <= r_data[w_idx][w_victim];
            end else begin
              r_state    <= FILL;
              r_mem_we   <= 1'b0;
              r_mem_addr <= {bus.addr[31:2], 2'b00};
            end
          end
        end
        WB: begin
          if (bus.mem_ready) begin
            r_state    <= FILL;
            r_mem_we   <= 1'b0;
            r_mem_addr <= {r_cap_tag, r_cap_idx, 2'b00};
          end
        end
        FILL: begin
          if (bus.mem_ready) begin
            r_state                        <= IDLE;
            r_mem_req                      <= 1'b0;
            r_valid[r_cap_idx][r_cap_way]  <= 1'b1;
            r_dirty[r_cap_idx][r_cap_way]  <= 1'b0;
            r_rr[r_cap_idx]                <= (WAYS == 1) ? '0 : r_rr[r_cap_idx] + 1'b1;
          end
        end
        FLUSH: begin
          if (!r_mem_req && w_fl_dirty) begin
            r_mem_req   <= 1'b1;
            r_mem_we    <= 1'b1;
            r_mem_addr  <= {r_tag[r_fl_set][r_fl_way], r_fl_set, 2'b00};
            r_mem_wdata <= r_data[r_fl_set][r_fl_way];
          end
          if (r_mem_req && bus.mem_ready) begin
            r_mem_req                   <= 1'b0;
            r_dirty[r_fl_set][r_fl_way] <= 1'b0;
          end
          if (w_fl_step) begin
            if (w_fl_last) r_state <= IDLE;
            if (w_fl_way_end) begin
              r_fl_way <= '0;
              r_fl_set <= r_fl_set + 1'b1;
            end else begin
              r_fl_way <= r_fl_way + 1'b1;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Line storage carries no reset; the valid bits decide whether it means anything.
  always_ff @(posedge clk) begin
    if (w_hit && bus.req_we)
      r_data[w_idx][w_hit_way] <= store_merge(r_data[w_idx][w_hit_way], bus.wdata,
                                              bus.funct3, bus.addr[1:0]);
    if ((r_state == FILL) && bus.mem_ready) begin
      r_data[r_cap_idx][r_cap_way] <= bus.mem_rdata;
      r_tag[r_cap_idx][r_cap_way]  <= r_cap_tag;
    end
  end
endmodule

// File: tb/tb_dcache_ctrl.sv
// Directed bench for dcache_ctrl (WAYS=2, SETS=64): misses, extension, eviction,
// writeback hold, reset mid-fill and flush ordering.
module tb_dcache_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  dcache_ctrl_if bus();
  dcache_ctrl #(.WAYS(2), .SETS(64)) dut (.clk(clk), .rst(rst), .bus(bus));

  int          n_tests = 0;
  int          n_fail  = 0;
  int          ntx;
  int          stalls;
  logic        tx_we    [8];
  logic [31:0] tx_addr  [8];
  logic [31:0] tx_wdata [8];
  logic [31:0] a0, d0;
  logic        we0, ok;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; bus.req_valid = 1'b0; bus.flush = 1'b0; bus.mem_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
  endtask

  task automatic drive(input logic we, input logic [31:0] a, input logic [31:0] wd,
                       input logic [2:0] f3);
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_we = we; bus.addr = a; bus.wdata = wd; bus.funct3 = f3;
    #1;
  endtask

  // Issues a request (or a flush pulse) and plays memory until stall drops; the
  // request is left asserted so the caller can inspect the hit cycle.
  task automatic do_req(input logic fl, input logic we, input logic [31:0] a,
                        input logic [31:0] wd, input logic [2:0] f3, input int wait_cyc,
                        input logic [31:0] fdata);
    int w = 0;
    bit done = 1'b0;
    ntx = 0; stalls = 0;
    @(negedge clk);
    bus.flush = fl; bus.req_valid = !fl; bus.req_we = we; bus.addr = a;
    bus.wdata = wd; bus.funct3 = f3;
    for (int c = 0; c < 400 && !done; c++) begin
      #1;
      if (!bus.stall && !(fl && c == 0)) begin
        done = 1'b1;
      end else begin
        if (bus.stall) stalls++;
        if (bus.mem_req) begin
          if (w == wait_cyc) begin
            bus.mem_ready = 1'b1; bus.mem_rdata = fdata;
            if (ntx < 8) begin
              tx_we[ntx] = bus.mem_we; tx_addr[ntx] = bus.mem_addr; tx_wdata[ntx] = bus.mem_wdata;
            end
            ntx++; w = 0;
          end else begin
            w++;
          end
        end
        @(negedge clk);
        bus.mem_ready = 1'b0; bus.flush = 1'b0;
      end
    end
    check("req_completes", 32'(done), 32'd1);
  endtask

  initial begin
    bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.addr = '0; bus.wdata = '0;
    bus.funct3 = 3'b010; bus.flush = 1'b0; bus.mem_ready = 1'b0; bus.mem_rdata = '0;
    do_reset();
    check("rst_stall",     32'(bus.stall),   32'd0);
    check("rst_mem_req",   32'(bus.mem_req), 32'd0);
    check("rst_mem_we",    32'(bus.mem_we),  32'd0);
    check("rst_mem_addr",  bus.mem_addr,     32'd0);
    check("rst_mem_wdata", bus.mem_wdata,    32'd0);

    // Cold load with a three-cycle memory wait.
    do_req(1'b0, 1'b0, 32'h100, 32'd0, 3'b010, 3, 32'hDEADBEEF);
    check("cold_stall_cycles", 32'(stalls), 32'd5);
    check("cold_ntx",          32'(ntx),    32'd1);
    check("cold_fill_addr",    tx_addr[0],  32'h100);
    check("cold_fill_we",      32'(tx_we[0]), 32'd0);
    check("cold_rdata",        bus.rdata,   32'hDEADBEEF);
    check("cold_hit_stall",    32'(bus.stall), 32'd0);

    // Load extension on a line holding 0x80FF7F01.
    do_req(1'b0, 1'b0, 32'h200, 32'd0, 3'b010, 0, 32'h80FF7F01);
    check("ext_fill_ntx", 32'(ntx), 32'd1);
    drive(1'b0, 32'h200, 32'd0, 3'b000); check("lb_0",  bus.rdata, 32'h00000001);
    check("lb_0_stall", 32'(bus.stall), 32'd0);
    drive(1'b0, 32'h203, 32'd0, 3'b000); check("lb_3",  bus.rdata, 32'hFFFFFF80);
    drive(1'b0, 32'h203, 32'd0, 3'b100); check("lbu_3", bus.rdata, 32'h00000080);
    drive(1'b0, 32'h202, 32'd0, 3'b001); check("lh_2",  bus.rdata, 32'hFFFF80FF);
    drive(1'b0, 32'h202, 32'd0, 3'b101); check("lhu_2", bus.rdata, 32'h000080FF);
    drive(1'b0, 32'h200, 32'd0, 3'b001); check("lh_0",  bus.rdata, 32'h00007F01);
    drive(1'b0, 32'h203, 32'd0, 3'b111); check("f3_other_word", bus.rdata, 32'h80FF7F01);
    drive(1'b0, 32'h100, 32'd0, 3'b010); check("other_way_hit", bus.rdata, 32'hDEADBEEF);

    // Store hits touch only their lanes.
    drive(1'b1, 32'h201, 32'h000000AA, 3'b000); check("sb_hit_stall", 32'(bus.stall), 32'd0);
    drive(1'b0, 32'h200, 32'd0, 3'b010);        check("sb_merge", bus.rdata, 32'h80FFAA01);
    drive(1'b1, 32'h202, 32'h00005555, 3'b001);
    drive(1'b0, 32'h200, 32'd0, 3'b010);        check("sh_merge", bus.rdata, 32'h5555AA01);

    // Eviction of a dirty line within set 0.
    do_reset();
    do_req(1'b0, 1'b1, 32'h000, 32'h11111111, 3'b010, 1, 32'd0);
    check("ev1_ntx", 32'(ntx), 32'd1);
    do_req(1'b0, 1'b1, 32'h400, 32'h11111111, 3'b010, 1, 32'd0);
    check("ev2_ntx", 32'(ntx), 32'd1);
    do_req(1'b0, 1'b1, 32'h800, 32'h11111111, 3'b010, 1, 32'd0);
    check("ev3_ntx",       32'(ntx),      32'd2);
    check("ev3_wb_we",     32'(tx_we[0]), 32'd1);
    check("ev3_wb_addr",   tx_addr[0],    32'h000);
    check("ev3_wb_data",   tx_wdata[0],   32'h11111111);
    check("ev3_fill_we",   32'(tx_we[1]), 32'd0);
    check("ev3_fill_addr", tx_addr[1],    32'h800);
    check("ev3_latency",   32'(stalls),   32'd5);

    // Writeback outputs hold steady while memory is slow.
    drive(1'b0, 32'hC00, 32'd0, 3'b010);
    check("hold_miss_stall", 32'(bus.stall), 32'd1);
    @(negedge clk); #1;
    a0 = bus.mem_addr; d0 = bus.mem_wdata; we0 = bus.mem_we;
    check("hold_wb_addr", a0, 32'h400);
    check("hold_wb_data", d0, 32'h11111111);
    check("hold_wb_we",   32'(we0), 32'd1);
    ok = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk); #1;
      if (bus.mem_addr !== a0 || bus.mem_wdata !== d0 || bus.mem_we !== we0 ||
          bus.stall !== 1'b1 || bus.mem_req !== 1'b1) ok = 1'b0;
    end
    check("hold_stable_20", 32'(ok), 32'd1);
    do_req(1'b0, 1'b0, 32'hC00, 32'd0, 3'b010, 0, 32'hCAFEF00D);
    check("hold_ntx",       32'(ntx),   32'd2);
    check("hold_fill_addr", tx_addr[1], 32'hC00);
    check("hold_rdata",     bus.rdata,  32'hCAFEF00D);

    // Reset while a fill is outstanding.
    drive(1'b0, 32'h1008, 32'd0, 3'b010);
    @(negedge clk); #1;
    check("midfill_req", 32'(bus.mem_req), 32'd1);
    check("midfill_addr", bus.mem_addr, 32'h1008);
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0; bus.req_valid = 1'b0; #1;
    check("midfill_rst_req",   32'(bus.mem_req), 32'd0);
    check("midfill_rst_stall", 32'(bus.stall),   32'd0);
    do_req(1'b0, 1'b0, 32'h1008, 32'd0, 3'b010, 0, 32'h12345678);
    check("midfill_remiss_ntx", 32'(ntx), 32'd1);
    check("midfill_rdata", bus.rdata, 32'h12345678);

    // Flush writes back set 0 way 1 then set 5 way 0.
    do_req(1'b0, 1'b0, 32'h000, 32'd0, 3'b010, 0, 32'h0A0A0A0A);
    do_req(1'b0, 1'b1, 32'h400, 32'h22222222, 3'b010, 0, 32'd0);
    do_req(1'b0, 1'b1, 32'h014, 32'h33333333, 3'b010, 0, 32'd0);
    do_req(1'b1, 1'b0, 32'd0, 32'd0, 3'b010, 2, 32'd0);
    check("flush_ntx",    32'(ntx),      32'd2);
    check("flush_wb0_we", 32'(tx_we[0]), 32'd1);
    check("flush_wb0",    tx_addr[0],    32'h400);
    check("flush_wb0_d",  tx_wdata[0],   32'h22222222);
    check("flush_wb1",    tx_addr[1],    32'h014);
    check("flush_wb1_d",  tx_wdata[1],   32'h33333333);
    drive(1'b0, 32'h400, 32'd0, 3'b010);
    check("post_flush_hit_400", bus.rdata, 32'h22222222);
    check("post_flush_stall",   32'(bus.stall),   32'd0);
    check("post_flush_no_req",  32'(bus.mem_req), 32'd0);
    drive(1'b0, 32'h014, 32'd0, 3'b010);
    check("post_flush_hit_014", bus.rdata, 32'h33333333);
    drive(1'b0, 32'h000, 32'd0, 3'b010);
    check("post_flush_hit_000", bus.rdata, 32'h0A0A0A0A);
    do_req(1'b1, 1'b0, 32'd0, 32'd0, 3'b010, 0, 32'd0);
    check("reflush_clean_ntx", 32'(ntx), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/dcache_ctrl.md
DCACHE_CTRL -- requirements
Module: dcache_ctrl

Interface
REQ-001 Parameter WAYS, default 2, associativity; SHALL be a power of two, 1..8.
REQ-002 Parameter SETS, default 64, number of sets; SHALL be a power of two, 4..1024.
REQ-003 Port clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-004 Port rst  input  1  reset; SHALL be synchronous and active-high.
REQ-005 Port req_valid  input  1  memory-stage access present (load or store).
REQ-006 Port req_we  input  1  1 = store, 0 = load.
REQ-007 Port addr  input  32  byte address.
REQ-008 Port wdata  input  32  store data, right-aligned.
REQ-009 Port funct3  input  3  RV32 load/store width and sign code.
REQ-010 Port flush  input  1  one-cycle request to write back every dirty line.
REQ-011 Port rdata  output  32  load result, sign- or zero-extended.
REQ-012 Port stall  output  1  freeze upstream pipeline while high.
REQ-013 Port mem_req  output  1  main-memory transaction request.
REQ-014 Port mem_we  output  1  1 = writeback, 0 = fill.
REQ-015 Port mem_addr  output  32  word-aligned memory address.
REQ-016 Port mem_wdata  output  32  writeback data.
REQ-017 Port mem_ready  input  1  memory completes the current transaction this cycle.
REQ-018 Port mem_rdata  input  32  fill data, valid when mem_ready=1.

Function
REQ-019 Organisation SHALL be one 32-bit word per line: index = addr[2+log2(SETS)-1:2], tag = the remaining upper bits; write-back, write-allocate policy.
REQ-020 Each way SHALL hold valid, dirty, tag and data; each set SHALL hold a log2(WAYS)-bit round-robin victim pointer.
REQ-021 In IDLE with req_valid=1 and a tag match in a valid way (hit), stall SHALL be 0 and rdata SHALL be combinationally valid in the same cycle.
REQ-022 Load extraction: LB (000) and LBU (100) use byte addr[1:0]; LH (001) and LHU (101) use half addr[1]; LW (010) ignores addr[1:0]; 000 and 001 SHALL sign-extend, 100 and 101 SHALL zero-extend; other codes SHALL return the full word.
REQ-023 Store hit: SB, SH or SW SHALL update only the addressed lanes at the clock edge and set dirty; rdata is don't-care.
REQ-024 Miss (req_valid=1, no hit, in IDLE): stall SHALL be 1 in the same cycle; victim = lowest-index invalid way, else the set's round-robin pointer.
REQ-025 FSM states: IDLE, WB, FILL, FLUSH. IDLE->WB on a miss with a valid, dirty victim; IDLE->FILL on a miss with a clean or invalid victim; WB->FILL on mem_ready; FILL->IDLE on mem_ready.
REQ-026 WB: mem_req=1, mem_we=1, mem_addr={victim tag, index, 2'b00}, mem_wdata=victim data; all outputs SHALL stay stable until mem_ready.
REQ-027 FILL: mem_req=1, mem_we=0, mem_addr={addr[31:2], 2'b00}; on mem_ready install mem_rdata with valid=1, dirty=0, the new tag, and advance the set's victim pointer modulo WAYS.
REQ-028 After FILL the FSM SHALL be in IDLE, and the same held request SHALL then hit; miss latency SHALL be (fill wait + 2) cycles, or (writeback wait + fill wait + 3) cycles when a writeback is needed.
REQ-029 stall SHALL be 1 in every non-IDLE state and during a miss cycle in IDLE; stall SHALL be 0 in IDLE when req_valid=0.
REQ-030 flush=1 in IDLE SHALL enter FLUSH, which scans set/way pairs in ascending order (set-major) and performs one writeback per dirty valid line, clearing dirty on mem_ready. The FSM SHALL return to IDLE after the last pair; lines stay valid.
REQ-031 flush has priority over a simultaneous req_valid; a flush pulse while not in IDLE SHALL be ignored.
REQ-032 mem_req SHALL be 0 in IDLE; no second transaction SHALL start in the cycle that mem_ready completes the previous one, except the WB->FILL transition.

Reset
REQ-033 rst=1 SHALL clear all valid bits, dirty bits and victim pointers, force IDLE, and drive stall=0, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0 from the following cycle.
REQ-034 rst asserted during WB, FILL or FLUSH SHALL abandon the transaction; dirty data is discarded and the pending mem_ready is ignored.

Verification
REQ-035 Cold load: after reset, LW addr=0x100, mem_ready returned 3 cycles after mem_req with mem_rdata=0xDEADBEEF -> stall high for 5 cycles, mem_addr=0x100, then rdata=0xDEADBEEF with stall=0.
REQ-036 Extension: line holds 0x80FF7F01; LB at +0 -> 0x00000001; LB at +3 -> 0xFFFFFF80; LBU at +3 -> 0x00000080; LH at +2 -> 0xFFFF80FF; LHU at +2 -> 0x000080FF.
REQ-037 Eviction with WAYS=2: SW 0x11111111 to 0x000, 0x400 and 0x800 (SETS=64, same set) -> the third store issues a writeback of 0x11111111 to 0x000, then a fill of 0x800.
REQ-038 Flush: dirty lines in set 0 way 1 and set 5 way 0 -> exactly two writebacks, in that order; stall remains high until the second mem_ready; a reload of either address then hits without mem_req.
REQ-039 Reset mid-FILL: rst asserted while waiting for mem_ready -> mem_req=0 the next cycle, and a subsequent access to the same address misses.
REQ-040 Stall stability: hold mem_ready=0 for 20 cycles in WB -> mem_addr, mem_wdata and mem_we remain unchanged and stall stays 1.
